// File: rtl/mem_req_scheduler.sv
// rtl/mem_req_scheduler.sv - two-port round-robin request arbiter with tREFI refresh insertion,
// issuing one command at a time to the DDR4 command FSM and returning tagged completions.
module mem_req_scheduler #(
  parameter int TAGW         = 4,
  parameter int ROWW         = 17,
  parameter int COLW         = 10,
  parameter int REF_INTERVAL = 7800,
  parameter int REF_MAX      = 8,
  parameter int AP_POLICY    = 0,
  parameter int TIMEOUT      = 1023
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_rw,
  input  logic [2*(ROWW+4+COLW)-1:0]    req_addr,
  input  logic [2*TAGW-1:0]             req_tag,
  output logic                          fsm_start,
  output logic                          fsm_rw,
  output logic                          fsm_refresh,
  output logic                          fsm_ap,
  output logic [1:0]                    fsm_bank,
  output logic [1:0]                    fsm_bankgroup,
  output logic [ROWW-1:0]               fsm_row,
  output logic [COLW-1:0]               fsm_column,
  output logic [TAGW-1:0]               fsm_tag,
  input  logic                          fsm_done,
  output logic                          rsp_valid,
  output logic                          rsp_port,
  output logic [TAGW-1:0]               rsp_tag,
  output logic                          busy,
  output logic [3:0]                    ref_pending,
  output logic                          err_timeout,
  output logic                          err_ref_ovf
);

  localparam int AW = ROWW + 4 + COLW;
  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REF_INTERVAL - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);
  localparam logic [3:0]    PEND_MAX   = 4'(REF_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RSP   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      ref_pend_q, ref_pend_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_ref_ovf_q, err_ref_ovf_d;
  logic            cmd_refresh_q, cmd_refresh_d;
  logic            cmd_rw_q, cmd_rw_d;
  logic            cmd_ap_q, cmd_ap_d;
  logic            cmd_port_q, cmd_port_d;
  logic [1:0]      cmd_bank_q, cmd_bank_d;
  logic [1:0]      cmd_bg_q, cmd_bg_d;
  logic [ROWW-1:0] cmd_row_q, cmd_row_d;
  logic [COLW-1:0] cmd_col_q, cmd_col_d;
  logic [TAGW-1:0] cmd_tag_q, cmd_tag_d;

  logic [1:0]      grant;
  logic            gnt_port;
  logic [AW-1:0]   addr_sel;
  logic [TAGW-1:0] tag_sel;
  logic            timer_wrap;
  logic            ref_dec;

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    ref_pend_d    = ref_pend_q;
    wd_d          = wd_q;
    err_timeout_d = err_timeout_q;
    err_ref_ovf_d = err_ref_ovf_q;
    cmd_refresh_d = cmd_refresh_q;
    cmd_rw_d      = cmd_rw_q;
    cmd_ap_d      = cmd_ap_q;
    cmd_port_d    = cmd_port_q;
    cmd_bank_d    = cmd_bank_q;
    cmd_bg_d      = cmd_bg_q;
    cmd_row_d     = cmd_row_q;
    cmd_col_d     = cmd_col_q;
    cmd_tag_d     = cmd_tag_q;
    grant         = 2'b00;

    // Both valid: the port that did not win last time goes next.
    gnt_port   = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];
    addr_sel   = gnt_port ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    tag_sel    = gnt_port ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
    timer_wrap = (timer_q == TIMER_LAST);
    timer_d    = timer_wrap ? '0 : timer_q + 1'b1;
    ref_dec    = (state_q == ST_ISSUE) && cmd_refresh_q;

    case (state_q)
      ST_IDLE: begin
        if (ref_pend_q == PEND_MAX || (req_valid == 2'b00 && ref_pend_q != 4'd0)) begin
          cmd_refresh_d = 1'b1;
          cmd_rw_d      = 1'b0;
          cmd_ap_d      = 1'b0;
          cmd_bank_d    = '0;
          cmd_bg_d      = '0;
          cmd_row_d     = '0;
          cmd_col_d     = '0;
          cmd_tag_d     = '0;
          state_d       = ST_ISSUE;
        end else if (req_valid != 2'b00) begin
          grant         = gnt_port ? 2'b10 : 2'b01;
          rr_last_d     = gnt_port;
          cmd_refresh_d = 1'b0;
          cmd_port_d    = gnt_port;
          cmd_rw_d      = gnt_port ? req_rw[1] : req_rw[0];
          cmd_ap_d      = (AP_POLICY != 0);
          cmd_row_d     = addr_sel[AW-1 -: ROWW];
          cmd_bg_d      = addr_sel[COLW+3 -: 2];
          cmd_bank_d    = addr_sel[COLW+1 -: 2];
          cmd_col_d     = addr_sel[COLW-1:0];
          cmd_tag_d     = tag_sel;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fsm_done) begin
          state_d = cmd_refresh_q ? ST_IDLE : ST_RSP;
        end else if (wd_q == WD_LAST) begin
          // The command is dropped; the host never sees a completion for it.
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A credit landing on the same cycle a refresh issues cancels out.
    if (timer_wrap && !ref_dec) begin
      if (ref_pend_q == PEND_MAX) begin
        err_ref_ovf_d = 1'b1;
      end else begin
        ref_pend_d = ref_pend_q + 4'd1;
      end
    end else if (!timer_wrap && ref_dec) begin
      ref_pend_d = ref_pend_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_last_q     <= 1'b1;
      timer_q       <= '0;
      ref_pend_q    <= '0;
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
      err_ref_ovf_q <= 1'b0;
      cmd_refresh_q <= 1'b0;
      cmd_rw_q      <= 1'b0;
      cmd_ap_q      <= 1'b0;
      cmd_port_q    <= 1'b0;
      cmd_bank_q    <= '0;
      cmd_bg_q      <= '0;
      cmd_row_q     <= '0;
      cmd_col_q     <= '0;
      cmd_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      timer_q       <= timer_d;
      ref_pend_q    <= ref_pend_d;
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
      err_ref_ovf_q <= err_ref_ovf_d;
      cmd_refresh_q <= cmd_refresh_d;
      cmd_rw_q      <= cmd_rw_d;
      cmd_ap_q      <= cmd_ap_d;
      cmd_port_q    <= cmd_port_d;
      cmd_bank_q    <= cmd_bank_d;
      cmd_bg_q      <= cmd_bg_d;
      cmd_row_q     <= cmd_row_d;
      cmd_col_q     <= cmd_col_d;
      cmd_tag_q     <= cmd_tag_d;
    end
  end

  assign req_ready     = reset ? 2'b00 : grant;
  assign fsm_start     = (state_q == ST_ISSUE);
  assign fsm_rw        = cmd_rw_q;
  assign fsm_refresh   = cmd_refresh_q;
  assign fsm_ap        = cmd_ap_q;
  assign fsm_bank      = cmd_bank_q;
  assign fsm_bankgroup = cmd_bg_q;
  assign fsm_row       = cmd_row_q;
  assign fsm_column    = cmd_col_q;
  assign fsm_tag       = cmd_tag_q;
  assign rsp_valid     = (state_q == ST_RSP);
  assign rsp_port      = rsp_valid & cmd_port_q;
  assign rsp_tag       = rsp_valid ? cmd_tag_q : '0;
  assign busy          = (state_q != ST_IDLE);
  assign ref_pending   = ref_pend_q;
  assign err_timeout   = err_timeout_q;
  assign err_ref_ovf   = err_ref_ovf_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb/tb_mem_req_scheduler.sv - directed bench for mem_req_scheduler: cycle tables plus
// round-robin, refresh, timeout, overflow and mid-command reset sequences.
module tb_mem_req_scheduler;
  localparam int TAGW = 4;
  localparam int ROWW = 17;
  localparam int COLW = 10;
  localparam int AW   = ROWW + 4 + COLW;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready;
  logic [1:0]        req_rw = 2'b00;
  logic [2*AW-1:0]   req_addr = '0;
  logic [2*TAGW-1:0] req_tag = '0;
  logic              fsm_start, fsm_rw, fsm_refresh, fsm_ap;
  logic [1:0]        fsm_bank, fsm_bankgroup;
  logic [ROWW-1:0]   fsm_row;
  logic [COLW-1:0]   fsm_column;
  logic [TAGW-1:0]   fsm_tag;
  logic              fsm_done = 1'b0;
  logic              rsp_valid, rsp_port;
  logic [TAGW-1:0]   rsp_tag;
  logic              busy;
  logic [3:0]        ref_pending;
  logic              err_timeout, err_ref_ovf;

  always #5 clock = ~clock;

  mem_req_scheduler #(
    .TAGW(TAGW), .ROWW(ROWW), .COLW(COLW), .REF_INTERVAL(16), .REF_MAX(2),
    .AP_POLICY(1), .TIMEOUT(20)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_tag(req_tag), .fsm_start(fsm_start),
    .fsm_rw(fsm_rw), .fsm_refresh(fsm_refresh), .fsm_ap(fsm_ap), .fsm_bank(fsm_bank),
    .fsm_bankgroup(fsm_bankgroup), .fsm_row(fsm_row), .fsm_column(fsm_column),
    .fsm_tag(fsm_tag), .fsm_done(fsm_done), .rsp_valid(rsp_valid), .rsp_port(rsp_port),
    .rsp_tag(rsp_tag), .busy(busy), .ref_pending(ref_pending), .err_timeout(err_timeout),
    .err_ref_ovf(err_ref_ovf)
  );

  typedef struct {
    int         n;
    logic [1:0] v;
    logic       d;
    logic [53:0] e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[16];
  logic [34:0] c0, c1;
  int g, r, dly, nref, maxp, nrsp, ns, gb, rs, ga, n0, n1;
  logic [3:0] t0, t1;
  logic [1:0] ep[16];
  logic [3:0] et[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // flags order: start, refresh, rw, ap, rsp_valid, rsp_port, busy
  function automatic logic [53:0] ev(input logic [1:0] rdy, input logic [6:0] f,
                                     input logic [3:0] rt, input logic [3:0] pd,
                                     input logic [34:0] cmd);
    return {rdy, f, rt, pd, cmd, 2'b00};
  endfunction

  function automatic logic [53:0] act_vec();
    return {req_ready, fsm_start, fsm_refresh, fsm_rw, fsm_ap, rsp_valid, rsp_port, busy,
            rsp_tag, ref_pending, fsm_row, fsm_bankgroup, fsm_bank, fsm_column, fsm_tag,
            err_timeout, err_ref_ovf};
  endfunction

  function automatic vec_t mkv(input int n, input logic [1:0] v, input logic d,
                               input logic [53:0] e);
    vec_t x;
    x.n = n; x.v = v; x.d = d; x.e = e;
    return x;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    fsm_done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [AW-1:0] mk_addr(input logic [ROWW-1:0] row, input logic [1:0] bg,
                                            input logic [1:0] bk, input logic [COLW-1:0] col);
    return {row, bg, bk, col};
  endfunction

  initial begin
    c0 = {17'd5, 2'd1, 2'd2, 10'd8, 4'd3};
    c1 = {17'h1ABCD, 2'd3, 2'd0, 10'h3FF, 4'hA};
    tbl[0]  = mkv(1, 2'b01, 1'b0, ev(2'b01, 7'b0000000, 4'd0, 4'd0, 35'd0));
    tbl[1]  = mkv(1, 2'b00, 1'b0, ev(2'b00, 7'b1011001, 4'd0, 4'd0, c0));
    tbl[2]  = mkv(9, 2'b00, 1'b0, ev(2'b00, 7'b0011001, 4'd0, 4'd0, c0));
    tbl[3]  = mkv(1, 2'b00, 1'b1, ev(2'b00, 7'b0011001, 4'd0, 4'd0, c0));
    tbl[4]  = mkv(1, 2'b00, 1'b0, ev(2'b00, 7'b0011101, 4'd3, 4'd0, c0));
    tbl[5]  = mkv(2, 2'b00, 1'b0, ev(2'b00, 7'b0011000, 4'd0, 4'd0, c0));
    tbl[6]  = mkv(1, 2'b00, 1'b1, ev(2'b00, 7'b0011000, 4'd0, 4'd0, c0));
    tbl[7]  = mkv(1, 2'b00, 1'b0, ev(2'b00, 7'b0011000, 4'd0, 4'd1, c0));
    tbl[8]  = mkv(1, 2'b00, 1'b0, ev(2'b00, 7'b1100001, 4'd0, 4'd1, 35'd0));
    tbl[9]  = mkv(1, 2'b00, 1'b1, ev(2'b00, 7'b0100001, 4'd0, 4'd0, 35'd0));
    tbl[10] = mkv(1, 2'b00, 1'b0, ev(2'b00, 7'b0100000, 4'd0, 4'd0, 35'd0));
    tbl[11] = mkv(1, 2'b10, 1'b0, ev(2'b10, 7'b0100000, 4'd0, 4'd0, 35'd0));
    tbl[12] = mkv(1, 2'b00, 1'b0, ev(2'b00, 7'b1001001, 4'd0, 4'd0, c1));
    tbl[13] = mkv(1, 2'b00, 1'b1, ev(2'b00, 7'b0001001, 4'd0, 4'd0, c1));
    tbl[14] = mkv(1, 2'b00, 1'b0, ev(2'b00, 7'b0001111, 4'hA, 4'd0, c1));
    tbl[15] = mkv(1, 2'b00, 1'b0, ev(2'b00, 7'b0001000, 4'd0, 4'd0, c1));

    // Reset state
    do_reset();
    @(negedge clock);
    chk("reset_state", act_vec(), 54'd0);
    tick();

    // Single read on port 0, refresh, then a write on port 1
    req_rw   = 2'b01;
    req_addr = {mk_addr(17'h1ABCD, 2'd3, 2'd0, 10'h3FF), mk_addr(17'd5, 2'd1, 2'd2, 10'd8)};
    req_tag  = {4'hA, 4'd3};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        req_valid = tbl[i].v;
        fsm_done  = tbl[i].d;
        @(negedge clock);
        chk($sformatf("vec%0d_%0d", i, k), act_vec(), tbl[i].e);
        tick();
      end
    end

    // Round robin with both ports continuously valid
    do_reset();
    req_rw = 2'b01;
    t0 = 4'd0; t1 = 4'd8; g = 0; r = 0; dly = -1; nref = 0; maxp = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 500 && r < 12; c++) begin
      req_valid = {n1 < 6, n0 < 6};
      req_tag   = {t1, t0};
      req_addr  = {mk_addr(17'd1, 2'd0, 2'd1, {6'd0, t1}), mk_addr(17'd2, 2'd2, 2'd3, {6'd0, t0})};
      fsm_done  = (dly == 0);
      if (dly >= 0) dly--;
      @(negedge clock);
      if (fsm_start) begin
        dly = 2;
        if (fsm_refresh) nref++;
      end
      if (int'(ref_pending) > maxp) maxp = int'(ref_pending);
      if (req_ready != 2'b00 && g < 16) begin
        chk($sformatf("rr_grant%0d", g), req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
        ep[g] = {1'b0, req_ready[1]};
        et[g] = req_ready[1] ? t1 : t0;
        if (req_ready[1]) begin t1++; n1++; end else begin t0++; n0++; end
        g++;
      end
      if (rsp_valid && r < 16) begin
        chk($sformatf("rr_rsp_port%0d", r), rsp_port, ep[r]);
        chk($sformatf("rr_rsp_tag%0d", r), rsp_tag, et[r]);
        r++;
      end
      tick();
    end
    chk("rr_grants", g, 12);
    chk("rr_rsps", r, 12);
    chk("rr_refresh_seen", nref > 0, 1);
    chk("rr_pending_le_max", maxp <= 2, 1);
    chk("rr_errors", {err_timeout, err_ref_ovf}, 2'b00);

    // Idle refresh cadence
    do_reset();
    ns = 0; nrsp = 0; dly = -1;
    for (int c = 0; c < 60; c++) begin
      fsm_done = (dly == 0);
      if (dly >= 0) dly--;
      @(negedge clock);
      if (fsm_start) begin
        dly = 2;
        if (ns < 3) begin
          chk($sformatf("ref_start_cycle%0d", ns), c, 17 + 16 * ns);
          chk("ref_flags", {fsm_refresh, fsm_rw, fsm_ap}, 3'b100);
          chk("ref_addr", {fsm_row, fsm_bankgroup, fsm_bank, fsm_column}, 0);
        end
        ns++;
      end
      if (rsp_valid) nrsp++;
      tick();
    end
    chk("ref_count", ns, 3);
    chk("ref_no_rsp", nrsp, 0);

    // Refresh deferred behind a busy port until the credit limit
    do_reset();
    req_rw = 2'b01; req_tag = {4'd0, 4'd5};
    gb = 0; rs = -1; ga = -1; dly = -1;
    for (int c = 0; c < 50; c++) begin
      req_valid = 2'b01;
      fsm_done = (dly == 0);
      if (dly >= 0) dly--;
      @(negedge clock);
      if (c == 36) chk("defer_pending_at_max", ref_pending, 4'd2);
      if (fsm_start) begin
        dly = 2;
        if (fsm_refresh && rs < 0) rs = c;
      end
      if (req_ready[0]) begin
        if (rs < 0) gb++;
        else if (ga < 0) ga = c;
      end
      tick();
    end
    chk("defer_grants_before_ref", gb, 6);
    chk("defer_ref_start", rs, 37);
    chk("defer_grant_after_ref", ga, 41);
    chk("defer_no_ovf", err_ref_ovf, 0);

    // Watchdog timeout, regrant, and credit overflow while refresh also hangs
    do_reset();
    nrsp = 0;
    for (int c = 0; c < 70; c++) begin
      req_valid = 2'b01;
      fsm_done  = 1'b0;
      @(negedge clock);
      if (c == 21) chk("to_before", {err_timeout, busy}, 2'b01);
      if (c == 22) chk("to_set_regrant", {err_timeout, busy, req_ready}, 4'b1001);
      if (c == 45) chk("to_ref_preempt", {fsm_start, fsm_refresh}, 2'b11);
      if (c == 63) chk("ovf_before", err_ref_ovf, 0);
      if (c == 64) chk("ovf_set", {err_ref_ovf, ref_pending}, 5'b10010);
      if (rsp_valid) nrsp++;
      tick();
    end
    chk("to_no_rsp", nrsp, 0);

    // Reset while waiting on the FSM; late done must be ignored
    do_reset();
    req_valid = 2'b01;
    @(negedge clock);
    chk("rst6_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    for (int c = 1; c < 5; c++) begin
      @(negedge clock);
      if (c == 4) chk("rst6_waiting", {busy, fsm_start}, 2'b10);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst6_outputs_zero", act_vec(), 54'd0);
    tick();
    fsm_done = 1'b1;
    @(negedge clock);
    chk("rst6_late_done", {rsp_valid, busy, fsm_start}, 3'b000);
    tick();
    fsm_done = 1'b0;
    @(negedge clock);
    chk("rst6_idle", act_vec(), 54'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
